// File: rtl/quad_step_decoder_pkg.sv
// Shared phase codes, direction constants and the up-sequence successor
// function for the quadrature step decoder.
package quad_pkg;

  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_10 = 2'b10;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_01 = 2'b01;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  // Successor of a phase in the up sequence 00 -> 10 -> 11 -> 01 -> 00.
  // A down step from p to q is the same relation read backwards: p == next_up(q).
  function automatic logic [1:0] next_up(input logic [1:0] phase);
    case (phase)
      PH_00:   next_up = PH_10;
      PH_10:   next_up = PH_11;
      PH_11:   next_up = PH_01;
      default: next_up = PH_00;
    endcase
  endfunction

endpackage

// File: rtl/quad_step_decoder_sync.sv
// Multi-flop synchronizer for one asynchronous encoder phase input.
// Clears to 0 on reset so the decoder always starts from phase 00.
module quad_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic Clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain_p0;

  // Shift the raw pin level through the chain; the oldest bit is the safe output.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      chain_p0 <= '0;
    end else begin
      chain_p0 <= {chain_p0[SYNC_STAGES-2:0], d};
    end
  end

  assign q = chain_p0[SYNC_STAGES-1];

endmodule

// File: rtl/quad_step_decoder.sv
// Quadrature decoder: synchronizes encoder phases A/B, decodes single-bit
// phase transitions into step/direction pulses, keeps a wrapping position
// count and flags illegal double-bit jumps with a sticky error.
module quad_step_decoder
  import quad_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             Clk,
  input  logic             reset_n,
  input  logic             QuadA,
  input  logic             QuadB,
  input  logic             Clear,
  input  logic             ErrClr,
  output logic [WIDTH-1:0] Count,
  output logic             Step,
  output logic             Dir,
  output logic             Error
);

  localparam int                FILL_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [FILL_W-1:0] FILL_DONE = FILL_W'(SYNC_STAGES + 1);

  logic              a_sync;
  logic              b_sync;
  logic [1:0]        cur;
  logic [1:0]        prev;
  logic [FILL_W-1:0] fill;
  logic              primed;
  logic              is_up;
  logic              is_down;
  logic              is_bad;

  quad_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_a (
    .Clk     (Clk),
    .reset_n (reset_n),
    .d       (QuadA),
    .q       (a_sync)
  );

  quad_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_b (
    .Clk     (Clk),
    .reset_n (reset_n),
    .d       (QuadB),
    .q       (b_sync)
  );

  // Decoding stays off until the sync chains and prev hold real pin levels,
  // so the level present at power-up is never mistaken for a transition.
  assign cur     = {a_sync, b_sync};
  assign primed  = (fill == FILL_DONE);
  assign is_up   = primed && (cur == next_up(prev));
  assign is_down = primed && (prev == next_up(cur));
  assign is_bad  = primed && ((cur ^ prev) == 2'b11);

  // Track the last decoded phase and count priming edges after reset.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      prev <= PH_00;
      fill <= '0;
    end else begin
      prev <= cur;
      if (!primed) begin
        fill <= fill + FILL_W'(1);
      end
    end
  end

  // Position count: wraps modulo 2^WIDTH; Clear overrides a coincident step.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      Count <= '0;
    end else if (Clear) begin
      Count <= '0;
    end else if (is_up) begin
      Count <= Count + WIDTH'(1);
    end else if (is_down) begin
      Count <= Count - WIDTH'(1);
    end
  end

  // Step pulse, last direction and sticky error; a new error beats ErrClr.
  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      Step  <= 1'b0;
      Dir   <= DIR_UP;
      Error <= 1'b0;
    end else begin
      Step <= is_up || is_down;
      if (is_up) begin
        Dir <= DIR_UP;
      end else if (is_down) begin
        Dir <= DIR_DOWN;
      end
      if (is_bad) begin
        Error <= 1'b1;
      end else if (ErrClr) begin
        Error <= 1'b0;
      end
    end
  end

endmodule

// File: doc/quad_step_decoder.md
# quad_step_decoder

Quadrature decoder that turns a two-phase encoder signal pair (A/B) into a step/direction stream and a wrapping up/down position count. It is the receive end of the up/down counting path. The external encoder produces the direction, and this block recovers it and maintains the count. It sits between asynchronous encoder pins and the downstream counting/control logic, and it flags illegal phase jumps.

## Interface
- WIDTH, 4: position count width in bits.
- SYNC_STAGES, 2: synchronizer depth per input. Legal range is 2–3.

Clocking and reset (already decided): one clock; reset is asynchronous and active-low.

- Clk  in  1  system clock. All state updates on its rising edge.
- reset_n  in  1  asynchronous active-low reset.
- QuadA  in  1  encoder phase A. Asynchronous to Clk.
- QuadB  in  1  encoder phase B. Asynchronous to Clk.
- Clear  in  1  synchronous clear of Count.
- ErrClr  in  1  synchronous clear of Error.
- Count  out  WIDTH  position count. Reset value 0.
- Step  out  1  one-cycle pulse per valid transition. Reset value 0.
- Dir  out  1  direction of the last valid step: 1 = up, 0 = down. Reset value 1.
- Error  out  1  sticky flag for an illegal double-bit transition. Reset value 0.

## Operation
- QuadA and QuadB each pass through a SYNC_STAGES flop chain. The synchronized phase is cur = {A,B}. Register prev holds the previously decoded phase.
- Up sequence: 00→10→11→01→00 (A leads B). The down sequence is the exact reverse.
- Decode rules, applied once primed:
  - cur == prev: no action.
  - One-bit change matching the up sequence: Step=1, Dir=1, Count+1.
  - One-bit change matching the down sequence: Step=1, Dir=0, Count−1.
  - Two-bit change (00↔11, 10↔01): Error=1, Step=0, Count and Dir unchanged.
  - In every case prev takes the value of cur.
- Wrap-around is required, modulo 2^WIDTH: up at 2^WIDTH−1 gives 0, and down at 0 gives 2^WIDTH−1. There is no saturation.
- Priming: after reset_n deasserts, a fill counter inhibits decoding for SYNC_STAGES+1 edges. During that window prev tracks cur and no Step or Error is produced, so the input level present at power-up never counts as a transition.
- Clear=1: Count becomes 0 at the next edge. If Clear coincides with a valid step, Clear wins (Count=0), but Step and Dir still report the step. prev updates normally.
- ErrClr=1 clears Error. If ErrClr coincides with a new illegal transition, set wins and Error stays 1.
- Reset asserted mid-operation: all flops go to their reset values immediately, sync chains and prev go to 00, and priming restarts.

## Timing
- Input change first sampled by synchronizer stage 1 at edge k → Count/Step/Dir/Error updated at edge k+SYNC_STAGES. That is 2 edges with the default depth.
- Step is high for exactly one cycle per valid transition. Consecutive transitions on consecutive synchronized samples give back-to-back Step pulses.
- Clear and ErrClr take effect at the next edge, with one cycle of latency.
- Maximum trackable input rate: one phase change per clock. Faster changes alias and may flag Error.

## Structure
- Package quad_pkg holds:
  - localparams for the four phase codes: PH_00, PH_10, PH_11, PH_01.
  - function next_up(phase), which returns the successor in the up sequence.
  - the DIR_UP/DIR_DOWN constants.
- Sub-module quad_sync: a parameterized SYNC_STAGES flop chain with asynchronous active-low reset to 0, instantiated once per phase.
- Top-level contents: the decode logic, prev register, fill counter, Count register and flag registers.

## Test plan
- Reset, priming and one up cycle:
  - Hold A=B=1 through reset and release.
  - Required: no Step and no Error during priming.
  - Then drive 11→01→00→10→11, with each phase held ≥4 clocks.
  - Required: 4 Step pulses, Dir=1, Count=4.
- Down wrap:
  - From Count=0, primed, A=B=0, drive 00→01.
  - Required: Count=15, Dir=0, one Step.
  - Then drive 01→11→10.
  - Required: Count=13.
- Illegal jump:
  - From 00, change A and B together to 11.
  - Required: Error=1, no Step, Count unchanged.
  - Pulse ErrClr.
  - Required: Error=0.
  - Then assert ErrClr in the same cycle a second 11→00 jump is decoded.
  - Required: Error=1.
- Clear collision:
  - At Count=7, assert Clear in the cycle an up step is decoded.
  - Required: Count=0, Step=1, Dir=1.
- Up wrap and latency:
  - Preload to 15 via steps, then do one up step.
  - Required: Count=0.
  - Also required: Step asserted exactly SYNC_STAGES edges after the first sampling edge.
- Mid-operation reset:
  - Pulse reset_n low mid-sequence.
  - Required: Count=0, Dir=1, Error=0 immediately.
  - Required: no spurious Step on release, even with A=1, B=0 at release.
